pipe_skid_reg: RTL and testbench

Parametrised elastic pipeline stage for the next-generation datapath. It replaces the plain write-enabled pipeline register with a valid/ready handshake and a 2-entry skid buffer, so that in_ready is driven from a flop. It keeps synchronous flush (bubble insertion) and adds saturating stall and bubble performance counters. One instance sits between each pair of pipeline stages; the payload width is set per stage.

---
 rtl/pipe_skid_reg.sv | 135 +++++++++++++
 tb/tb_pipe_skid_reg.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage: valid/ready handshake over a main register plus one skid entry,
// with synchronous flush and saturating stall/bubble counters.
module pipe_skid_reg #(
    parameter int unsigned          WIDTH     = 32,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             clear_cnt,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] bubble_count
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } occ_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    occ_e             state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    logic in_fire;
    logic out_fire;
    logic main_valid;
    logic skid_valid;
    logic stall_hit;
    logic bubble_hit;

    assign main_valid = (state_q != StEmpty);
    assign skid_valid = (state_q == StFull);
    assign in_fire    = in_valid & in_ready_q;
    assign out_fire   = main_valid & out_ready;

    // in_ready_q always mirrors "next state is not FULL", so it never depends on out_ready
    // combinationally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StEmpty;
            main_q     <= RESET_VAL;
            skid_q     <= RESET_VAL;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            state_q    <= StEmpty;
            main_q     <= RESET_VAL;
            skid_q     <= RESET_VAL;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_q <= StOne;
                        main_q  <= in_data;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        state_q    <= StFull;
                        skid_q     <= in_data;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        state_q    <= StOne;
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= StEmpty;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Qualifying conditions use the pre-flush state, so a flush cycle still counts.
    assign stall_hit  = main_valid & ~out_ready;
    assign bubble_hit = ~main_valid & out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else if (clear_cnt) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (stall_hit && (stall_q != CntMax)) begin
                stall_q <= stall_q + CntOne;
            end
            if (bubble_hit && (bubble_q != CntMax)) begin
                bubble_q <= bubble_q + CntOne;
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = main_valid;
    assign out_data     = main_q;
    assign occupancy    = state_q;
    assign stall_count  = stall_q;
    assign bubble_count = bubble_q;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (in_ready_q == !skid_valid)
                else $error("in_ready out of step with occupancy");
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (WIDTH=8, RESET_VAL=0xC3, CNT_W=4).
module tb_pipe_skid_reg;

    localparam int unsigned W  = 8;
    localparam logic [7:0]  RV = 8'hC3;
    localparam int unsigned CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          clear_cnt = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] bubble_count;

    int total = 0;
    int bad   = 0;

    pipe_skid_reg #(
        .WIDTH    (W),
        .RESET_VAL(RV),
        .CNT_W    (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .clear_cnt   (clear_cnt),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .occupancy   (occupancy),
        .stall_count (stall_count),
        .bubble_count(bubble_count)
    );

    always #5 clock = ~clock;

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Status checks compare {occupancy, out_valid, in_ready}.
    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        total++;
        if ({occupancy, out_valid, in_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_status got=%b want=%b", {occupancy, out_valid, in_ready}, 4'b0001);
        end
        total++;
        if (out_data !== RV) begin
            bad++;
            $display("FAIL reset_data got=%h want=%h", out_data, RV);
        end
        total++;
        if ({stall_count, bubble_count} !== 8'h00) begin
            bad++;
            $display("FAIL reset_counters got=%h want=%h", {stall_count, bubble_count}, 8'h00);
        end
        @(negedge clock);
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_single(input logic [7:0] val);
        in_valid  = 1'b1;
        in_data   = val;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        total++;
        if ({occupancy, out_valid, in_ready} !== 4'b0111) begin
            bad++;
            $display("FAIL single_status got=%b want=%b", {occupancy, out_valid, in_ready}, 4'b0111);
        end
        total++;
        if (out_data !== val) begin
            bad++;
            $display("FAIL single_data got=%h want=%h", out_data, val);
        end
        cycle();
        total++;
        if ({occupancy, out_valid, in_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL single_drain got=%b want=%b", {occupancy, out_valid, in_ready}, 4'b0001);
        end
        total++;
        if (out_data !== val) begin
            bad++;
            $display("FAIL single_keep got=%h want=%h", out_data, val);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        clear_cnt = 1'b1;
        cycle();
        clear_cnt = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            cycle();
            total++;
            if ({occupancy, out_valid, in_ready, out_data} !== {4'b0111, 8'(i)}) begin
                bad++;
                $display("FAIL b2b_item%0d got=%b/%h want=%b/%h", i,
                         {occupancy, out_valid, in_ready}, out_data, 4'b0111, 8'(i));
            end
        end
        in_valid = 1'b0;
        cycle();
        total++;
        if ({occupancy, out_valid, in_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL b2b_drain got=%b want=%b", {occupancy, out_valid, in_ready}, 4'b0001);
        end
        // Only the first item's cycle started from EMPTY with out_ready high.
        total++;
        if ({stall_count, bubble_count} !== 8'h01) begin
            bad++;
            $display("FAIL b2b_counters got=%h want=%h", {stall_count, bubble_count}, 8'h01);
        end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        clear_cnt = 1'b1;
        cycle();
        clear_cnt = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        cycle();
        total++;
        if ({occupancy, out_valid, in_ready, out_data} !== {4'b0111, 8'h11}) begin
            bad++;
            $display("FAIL full_first got=%b/%h want=%b/%h",
                     {occupancy, out_valid, in_ready}, out_data, 4'b0111, 8'h11);
        end
        in_data = 8'h22;
        cycle();
        total++;
        if ({occupancy, out_valid, in_ready, out_data} !== {4'b1010, 8'h11}) begin
            bad++;
            $display("FAIL full_second got=%b/%h want=%b/%h",
                     {occupancy, out_valid, in_ready}, out_data, 4'b1010, 8'h11);
        end
        in_data = 8'h33;
        cycle();
        total++;
        if ({occupancy, out_valid, in_ready, out_data} !== {4'b1010, 8'h11}) begin
            bad++;
            $display("FAIL full_hold got=%b/%h want=%b/%h",
                     {occupancy, out_valid, in_ready}, out_data, 4'b1010, 8'h11);
        end
        out_ready = 1'b1;
        cycle();
        total++;
        if ({occupancy, out_valid, in_ready, out_data} !== {4'b0111, 8'h22}) begin
            bad++;
            $display("FAIL full_pop1 got=%b/%h want=%b/%h",
                     {occupancy, out_valid, in_ready}, out_data, 4'b0111, 8'h22);
        end
        cycle();
        total++;
        if ({occupancy, out_valid, in_ready, out_data} !== {4'b0111, 8'h33}) begin
            bad++;
            $display("FAIL full_pop2 got=%b/%h want=%b/%h",
                     {occupancy, out_valid, in_ready}, out_data, 4'b0111, 8'h33);
        end
        in_valid = 1'b0;
        cycle();
        total++;
        if ({occupancy, out_valid, in_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL full_drain got=%b want=%b", {occupancy, out_valid, in_ready}, 4'b0001);
        end
        total++;
        if ({stall_count, bubble_count} !== 8'h20) begin
            bad++;
            $display("FAIL full_counters got=%h want=%h", {stall_count, bubble_count}, 8'h20);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        clear_cnt = 1'b1;
        cycle();
        clear_cnt = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        cycle();
        in_data = 8'h22;
        cycle();
        total++;
        if ({occupancy, out_valid, in_ready} !== 4'b1010) begin
            bad++;
            $display("FAIL flush_fill got=%b want=%b", {occupancy, out_valid, in_ready}, 4'b1010);
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        cycle();
        flush = 1'b0;
        total++;
        if ({occupancy, out_valid, in_ready, out_data} !== {4'b0001, RV}) begin
            bad++;
            $display("FAIL flush_full got=%b/%h want=%b/%h",
                     {occupancy, out_valid, in_ready}, out_data, 4'b0001, RV);
        end
        // The flush cycle itself still qualified as a stall.
        total++;
        if (stall_count !== 4'd2) begin
            bad++;
            $display("FAIL flush_stall_count got=%0d want=%0d", stall_count, 2);
        end
        in_valid = 1'b1;
        in_data  = 8'h77;
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++;
        if ({occupancy, out_valid, in_ready, out_data} !== {4'b0001, RV}) begin
            bad++;
            $display("FAIL flush_with_input got=%b/%h want=%b/%h",
                     {occupancy, out_valid, in_ready}, out_data, 4'b0001, RV);
        end
        out_ready = 1'b1;
        cycle();
        total++;
        if ({occupancy, out_valid, out_data} !== {3'b000, RV}) begin
            bad++;
            $display("FAIL flush_discard got=%b/%h want=%b/%h",
                     {occupancy, out_valid}, out_data, 3'b000, RV);
        end
    endtask

    task automatic test_saturate();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        clear_cnt = 1'b1;
        cycle();
        clear_cnt = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h44;
        cycle();
        in_valid = 1'b0;
        repeat (14) cycle();
        total++;
        if (stall_count !== 4'd14) begin
            bad++;
            $display("FAIL stall_14 got=%0d want=%0d", stall_count, 14);
        end
        repeat (6) cycle();
        total++;
        if (stall_count !== 4'd15) begin
            bad++;
            $display("FAIL stall_saturate got=%0d want=%0d", stall_count, 15);
        end
        total++;
        if ({occupancy, out_valid, in_ready, out_data} !== {4'b0111, 8'h44}) begin
            bad++;
            $display("FAIL stall_stable got=%b/%h want=%b/%h",
                     {occupancy, out_valid, in_ready}, out_data, 4'b0111, 8'h44);
        end
        clear_cnt = 1'b1;
        cycle();
        clear_cnt = 1'b0;
        total++;
        if ({stall_count, bubble_count} !== 8'h00) begin
            bad++;
            $display("FAIL clear_override got=%h want=%h", {stall_count, bubble_count}, 8'h00);
        end
        out_ready = 1'b1;
        cycle();
        total++;
        if ({occupancy, out_valid, stall_count, bubble_count} !== {3'b000, 8'h00}) begin
            bad++;
            $display("FAIL drain_no_count got=%h want=%h",
                     {occupancy, out_valid, stall_count, bubble_count}, {3'b000, 8'h00});
        end
        repeat (3) cycle();
        total++;
        if (bubble_count !== 4'd3) begin
            bad++;
            $display("FAIL bubble_3 got=%0d want=%0d", bubble_count, 3);
        end
        repeat (14) cycle();
        total++;
        if (bubble_count !== 4'd15) begin
            bad++;
            $display("FAIL bubble_saturate got=%0d want=%0d", bubble_count, 15);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        cycle();
        in_data = 8'h22;
        cycle();
        in_valid = 1'b0;
        total++;
        if ({occupancy, out_valid, in_ready} !== 4'b1010) begin
            bad++;
            $display("FAIL arst_fill got=%b want=%b", {occupancy, out_valid, in_ready}, 4'b1010);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({occupancy, out_valid, in_ready, out_data} !== {4'b0001, RV}) begin
            bad++;
            $display("FAIL arst_outputs got=%b/%h want=%b/%h",
                     {occupancy, out_valid, in_ready}, out_data, 4'b0001, RV);
        end
        total++;
        if ({stall_count, bubble_count} !== 8'h00) begin
            bad++;
            $display("FAIL arst_counters got=%h want=%h", {stall_count, bubble_count}, 8'h00);
        end
        @(negedge clock);
        reset = 1'b1;
        cycle();
        test_single(8'h5C);
    endtask

    initial begin
        test_reset();
        test_single(8'hA5);
        test_back_to_back();
        test_full();
        test_flush();
        test_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
